// File: rtl/wave_playback_pkg.sv
// Shared constants and FSM state type for the channel waveform playback path.
// Widths here must agree with the sample memory on the board top level.
package wave_playback_pkg;

  localparam int unsigned M     = 12;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 150;
  localparam int unsigned DIV_W = 8;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_OUT,
    ST_PACE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/wave_playback_ctrl_if.sv
// Control, memory-read and sample-stream signals of the playback sequencer.
// master = sequencer side, slave = surrounding memory/DAC/control side.
interface wave_playback_ctrl_if;
  import wave_playback_pkg::*;

  logic             trig;
  logic             abort;
  logic [DIV_W-1:0] rate_div;
  logic [AW-1:0]    mem_dir;
  logic [M-1:0]     mem_data;
  logic [M-1:0]     sample_out;
  logic             sample_valid;
  logic             sample_ready;
  logic             busy;
  logic             done;
  logic             trig_overrun;

  modport master (
    input  trig, abort, rate_div, mem_data, sample_ready,
    output mem_dir, sample_out, sample_valid, busy, done, trig_overrun
  );

  modport slave (
    output trig, abort, rate_div, mem_data, sample_ready,
    input  mem_dir, sample_out, sample_valid, busy, done, trig_overrun
  );

endinterface

// File: rtl/pace_counter.sv
// Loadable down-counter with zero flag; times the inter-sample gap.
module pace_counter
  import wave_playback_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  assign zero_c = (count_q == '0);

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !zero_c) begin
      count_q <= count_q - W'(1);
    end
  end

endmodule

// File: rtl/wave_playback_ctrl.sv
// Walks the sample memory 0..DEPTH-1 on trigger and streams each word out
// over valid/ready, with a latched inter-sample gap between samples.
module wave_playback_ctrl
  import wave_playback_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  wave_playback_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DIV_W-1:0] rate_q, rate_d;
  logic [AW-1:0]    mem_dir_q, mem_dir_d;
  logic [M-1:0]     sample_out_q, sample_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             pace_load, pace_dec, pace_zero_c;

  pace_counter #(.W(DIV_W)) u_pace (
    .clk      (clk),
    .reset    (reset),
    .load     (pace_load),
    .load_val (rate_q - DIV_W'(1)),
    .dec      (pace_dec),
    .zero_c   (pace_zero_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rate_q       <= '0;
      mem_dir_q    <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rate_q       <= rate_d;
      mem_dir_q    <= mem_dir_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rate_d       = rate_q;
    sample_out_d = sample_out_q;
    valid_d      = valid_q;
    pace_load    = 1'b0;
    pace_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.trig && !bus.abort) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          rate_d  = bus.rate_div;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        sample_out_d = bus.mem_data;
        valid_d      = 1'b1;
        state_d      = ST_OUT;
      end
      ST_OUT: begin
        if (bus.sample_ready) begin
          valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
            if (rate_q != '0) begin
              state_d   = ST_PACE;
              pace_load = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_PACE: begin
        if (pace_zero_c) state_d = ST_FETCH;
        else             pace_dec = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything outside IDLE and suppresses the done pulse.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      pace_load = 1'b0;
      pace_dec  = 1'b0;
    end

    mem_dir_d = (state_d == ST_IDLE) ? '0 : addr_d;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    overrun_d = bus.trig && (state_q != ST_IDLE);
  end

  assign bus.mem_dir      = mem_dir_q;
  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.trig_overrun = overrun_q;

endmodule

// File: tb/tb_wave_playback_ctrl.sv
// Directed bench for wave_playback_ctrl: memory word = address, stream
// monitor on the falling edge, hand-computed cycle counts per scenario.
module tb_wave_playback_ctrl;
  import wave_playback_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  wave_playback_ctrl_if bus ();

  wave_playback_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read sample memory, preloaded with value = address.
  logic [M-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_dir];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stream monitor, sampled at the falling edge.
  int       acc_val[$];
  int       acc_cyc[$];
  int       rise_q[$];
  int       done_cnt = 0;
  int       done_cyc = 0;
  int       ovr_cnt  = 0;
  int       hold_err = 0;
  logic     prev_valid = 1'b0;
  logic     prev_ready = 1'b0;
  logic [M-1:0] prev_out = '0;

  always @(negedge clk) begin
    if (bus.sample_valid && !prev_valid) rise_q.push_back(cyc);
    if (bus.sample_valid && bus.sample_ready) begin
      acc_val.push_back(int'(bus.sample_out));
      acc_cyc.push_back(cyc);
    end
    if (reset && prev_valid && !prev_ready &&
        !(bus.sample_valid && (bus.sample_out == prev_out)))
      hold_err <= hold_err + 1;
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.trig_overrun) ovr_cnt <= ovr_cnt + 1;
    prev_valid <= bus.sample_valid;
    prev_ready <= bus.sample_ready;
    prev_out   <= bus.sample_out;
  end

  task automatic clear_mon();
    acc_val.delete();
    acc_cyc.delete();
    rise_q.delete();
  endtask

  // Pulses trig for one cycle; tcyc is the cycle in which trig is sampled.
  task automatic run_play(input int rate, output int tcyc);
    @(posedge clk); #1;
    bus.rate_div = DIV_W'(rate);
    bus.trig     = 1'b1;
    @(negedge clk);
    tcyc = cyc;
    @(posedge clk); #1;
    bus.trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != base) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic wait_addr(input string tag, input int a, input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy && (int'(bus.mem_dir) == a)) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_addr_seen"}, ok, 1);
  endtask

  task automatic check_seq(input string tag, input int n);
    int bad = 0;
    check({tag, "_count"}, acc_val.size(), n);
    for (int i = 0; i < acc_val.size(); i++) if (acc_val[i] != i) bad++;
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic check_gaps(input string tag, input int q[$], input int g);
    int bad = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != g) bad++;
    check({tag, "_gaps"}, bad, 0);
  endtask

  function automatic int first_rise(input int tcyc);
    return (rise_q.size() > 0) ? rise_q[0] - tcyc : -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_dir"}, int'(bus.mem_dir), 0);
    check({tag, "_sample_out"}, int'(bus.sample_out), 0);
    check({tag, "_valid"}, int'(bus.sample_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_overrun"}, int'(bus.trig_overrun), 0);
  endtask

  initial begin
    int tcyc;
    int d0;
    int o0;
    int h0;

    for (int i = 0; i < (1 << AW); i++) mem[i] = M'(i);
    reset            = 1'b0;
    bus.trig         = 1'b0;
    bus.abort        = 1'b0;
    bus.rate_div     = '0;
    bus.sample_ready = 1'b1;

    #12;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // Rate 0, ready held: 150 samples 3 cycles apart, done 451 after trig.
    clear_mon();
    d0 = done_cnt;
    o0 = ovr_cnt;
    run_play(0, tcyc);
    check("t1_busy_fetch", int'(bus.busy), 1);
    check("t1_addr_fetch", int'(bus.mem_dir), 0);
    wait_done("t1", d0, 2000);
    check("t1_busy_in_done", int'(bus.busy), 1);
    check("t1_valid_latency", first_rise(tcyc), 3);
    check("t1_done_latency", done_cyc - tcyc, 451);
    check_seq("t1", 150);
    check_gaps("t1_accept", acc_cyc, 3);
    check("t1_overrun", ovr_cnt - o0, 0);
    @(negedge clk); #1;
    check("t1_busy_after", int'(bus.busy), 0);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_last_sample_kept", int'(bus.sample_out), 149);

    // Rate 4 latched at trig; a later rate_div change must not matter.
    clear_mon();
    d0 = done_cnt;
    run_play(4, tcyc);
    repeat (50) @(posedge clk);
    #1 bus.rate_div = '0;
    wait_done("t2", d0, 3000);
    check("t2_valid_latency", first_rise(tcyc), 3);
    check("t2_rise_count", rise_q.size(), 150);
    check_gaps("t2_rise", rise_q, 7);
    check("t2_done_latency", done_cyc - tcyc, 1047);
    check_seq("t2", 150);

    // Ten backpressure cycles on sample 37.
    clear_mon();
    d0 = done_cnt;
    h0 = hold_err;
    run_play(0, tcyc);
    wait_addr("t3", 37, 1000);
    @(posedge clk); #1 bus.sample_ready = 1'b0;
    repeat (11) @(posedge clk);
    #1 bus.sample_ready = 1'b1;
    check("t3_held_value", int'(bus.sample_out), 37);
    wait_done("t3", d0, 2000);
    check("t3_hold_errors", hold_err - h0, 0);
    check_seq("t3", 150);
    check("t3_gap_37", (acc_cyc.size() > 37) ? acc_cyc[37] - acc_cyc[36] : -1, 13);
    check("t3_done_latency", done_cyc - tcyc, 461);

    // Trig while busy: one overrun pulse, playback unaffected.
    clear_mon();
    d0 = done_cnt;
    o0 = ovr_cnt;
    run_play(0, tcyc);
    wait_addr("t4", 20, 1000);
    @(posedge clk); #1 bus.trig = 1'b1;
    @(posedge clk); #1 bus.trig = 1'b0;
    check("t4_overrun_pulse", int'(bus.trig_overrun), 1);
    wait_done("t4", d0, 2000);
    check("t4_overrun_count", ovr_cnt - o0, 1);
    check("t4_done_latency", done_cyc - tcyc, 451);
    check_seq("t4", 150);
    repeat (5) @(negedge clk);
    #1 check("t4_done_count", done_cnt - d0, 1);

    // Abort while sample 75 is being loaded; then a clean restart.
    clear_mon();
    d0 = done_cnt;
    run_play(0, tcyc);
    wait_addr("t5", 75, 1000);
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("t5_busy_after_abort", int'(bus.busy), 0);
    check("t5_valid_after_abort", int'(bus.sample_valid), 0);
    check("t5_addr_after_abort", int'(bus.mem_dir), 0);
    repeat (10) @(negedge clk);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    check_seq("t5_partial", 75);
    clear_mon();
    run_play(0, tcyc);
    check("t5_restart_addr", int'(bus.mem_dir), 0);
    wait_done("t5r", d0, 2000);
    check_seq("t5r", 150);

    // Asynchronous reset while a sample is presented.
    clear_mon();
    run_play(0, tcyc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sample_valid) break;
    end
    check("t6_valid_before_reset", int'(bus.sample_valid), 1);
    #2 reset = 1'b0;
    #1 check_idle_outputs("t6_async");
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("t6_busy_after_release", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
